// File: rtl/tivi_pkg.sv
// Shared text-video constants used by the bus interface,
// the framebuffer-port mux and the scroll/clear engine.
package tivi_pkg;

  localparam int TEXT_COLS = 80;
  localparam int TEXT_ROWS = 30;
  localparam int FB_AW     = 14;
  localparam int IDX_W     = 12;

  localparam logic CMD_SCROLL = 1'b0;
  localparam logic CMD_CLEAR  = 1'b1;

  typedef logic [7:0] char_t;

endpackage

// File: rtl/fb_scroller_if.sv
// Framebuffer CPU-port bundle: the engine is master while
// it owns the port, the framebuffer side is slave.
interface fb_scroller_if
  import tivi_pkg::*;
#(
  parameter int AW = FB_AW
);

  logic [AW-1:0] mem_addr;
  char_t         mem_wdata;
  logic          mem_wren;
  char_t         mem_rdata;
  logic          owner;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_wren,
    output owner,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_wren,
    input  owner,
    output mem_rdata
  );

endinterface

// File: rtl/fb_scroller.sv
// Text scroll-up / clear-screen engine that borrows the
// framebuffer CPU port and moves the cells on slot cycles.
module fb_scroller
  import tivi_pkg::*;
#(
  parameter int COLS = TEXT_COLS,
  parameter int ROWS = TEXT_ROWS,
  parameter int AW   = FB_AW,
  parameter int BASE = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          slot,
  input  logic          start,
  input  logic          cmd,
  input  char_t         fill,
  fb_scroller_if.master fb,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR,
    FILL,
    DONE
  } state_e;

  localparam logic [IDX_W-1:0] CPY_LAST =
    IDX_W'((ROWS - 1) * COLS - 1);
  localparam logic [IDX_W-1:0] FILL_FIRST =
    IDX_W'((ROWS - 1) * COLS);
  localparam logic [IDX_W-1:0] ALL_LAST =
    IDX_W'(ROWS * COLS - 1);
  localparam logic [AW-1:0] BASE_A = AW'(BASE);
  localparam logic [AW-1:0] COLS_A = AW'(COLS);

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  char_t            fill_q;
  char_t            wdata_q;
  logic [AW-1:0]    addr_q;
  logic             owner_q;
  logic             done_q;
  logic [AW-1:0]    cell_a;

  assign cell_a = BASE_A + AW'(idx_q);

  // Port drive is live only on slot cycles; otherwise the
  // last address/data are held and the write is dropped.
  always_comb begin
    fb.mem_addr  = addr_q;
    fb.mem_wdata = wdata_q;
    fb.mem_wren  = 1'b0;
    if (slot) begin
      case (state_q)
        RD: begin
          fb.mem_addr = cell_a + COLS_A;
        end
        WR: begin
          fb.mem_addr  = cell_a;
          fb.mem_wdata = fb.mem_rdata;
          fb.mem_wren  = 1'b1;
        end
        FILL: begin
          fb.mem_addr  = cell_a;
          fb.mem_wdata = fill_q;
          fb.mem_wren  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      fill_q  <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
      owner_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      addr_q  <= fb.mem_addr;
      wdata_q <= fb.mem_wdata;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            fill_q  <= fill;
            idx_q   <= '0;
            owner_q <= 1'b1;
            state_q <= (cmd == CMD_CLEAR) ? FILL : RD;
          end
        end
        RD: begin
          if (slot) state_q <= WR;
        end
        WR: begin
          if (slot) begin
            if (idx_q == CPY_LAST) begin
              idx_q   <= FILL_FIRST;
              state_q <= FILL;
            end else begin
              idx_q   <= idx_q + IDX_W'(1);
              state_q <= RD;
            end
          end
        end
        FILL: begin
          if (slot) begin
            if (idx_q == ALL_LAST) begin
              owner_q <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign fb.owner = owner_q;
  assign busy     = owner_q;
  assign done     = done_q;

endmodule

// File: tb/tb_fb_scroller.sv
// Directed bench for fb_scroller: scroll, clear, busy
// start, mid-op reset and address wrap at BASE=0x3F00.
module tb_fb_scroller;

  logic       clk;
  logic       reset;
  logic       slot;
  logic       start0;
  logic       start1;
  logic       cmd;
  logic [7:0] fill;
  logic       busy0, done0;
  logic       busy1, done1;
  bit         pre;

  fb_scroller_if #(.AW(14)) if0 ();
  fb_scroller_if #(.AW(14)) if1 ();

  fb_scroller #(
    .COLS(80), .ROWS(30), .AW(14), .BASE(0)
  ) u_dut0 (
    .clk(clk), .reset(reset), .slot(slot),
    .start(start0), .cmd(cmd), .fill(fill),
    .fb(if0.master), .busy(busy0), .done(done0)
  );

  fb_scroller #(
    .COLS(80), .ROWS(30), .AW(14), .BASE(16'h3F00)
  ) u_dut1 (
    .clk(clk), .reset(reset), .slot(slot),
    .start(start1), .cmd(cmd), .fill(fill),
    .fb(if1.master), .busy(busy1), .done(done1)
  );

  logic [7:0] fb0 [16384];
  logic [7:0] fb1 [16384];

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    slot = 0;
    forever begin
      @(posedge clk);
      #1 slot = ~slot;
    end
  end

  // Memory model: write and registered read on slot edges
  always @(posedge clk) begin
    if (pre) begin
      for (int i = 0; i < 16384; i++) fb0[i] <= 8'(i);
    end else if (slot) begin
      if (if0.mem_wren) fb0[if0.mem_addr] <= if0.mem_wdata;
      if0.mem_rdata <= fb0[if0.mem_addr];
    end
  end

  always @(posedge clk) begin
    if (pre) begin
      for (int i = 0; i < 16384; i++) fb1[i] <= 8'(i);
    end else if (slot) begin
      if (if1.mem_wren) fb1[if1.mem_addr] <= if1.mem_wdata;
      if1.mem_rdata <= fb1[if1.mem_addr];
    end
  end

  int dcnt0 = 0;
  int wbad0 = 0, wbad1 = 0;
  int pairs0 = 0, pairs1 = 0;
  int pbad0 = 0, pbad1 = 0;
  logic [13:0] ra0, ra1;
  bit rp0 = 0, rp1 = 0;

  always @(negedge clk) begin
    if (done0) dcnt0++;
    if (if0.mem_wren && !slot) wbad0++;
    if (reset) rp0 = 0;
    else if (slot && if0.owner && !if0.mem_wren) begin
      ra0 = if0.mem_addr;
      rp0 = 1;
    end else if (slot && if0.mem_wren) begin
      if (rp0) begin
        pairs0++;
        if (if0.mem_addr != ra0 - 14'd80) pbad0++;
      end
      rp0 = 0;
    end
  end

  always @(negedge clk) begin
    if (if1.mem_wren && !slot) wbad1++;
    if (reset) rp1 = 0;
    else if (slot && if1.owner && !if1.mem_wren) begin
      ra1 = if1.mem_addr;
      rp1 = 1;
    end else if (slot && if1.mem_wren) begin
      if (rp1) begin
        pairs1++;
        if (if1.mem_addr != ra1 - 14'd80) pbad1++;
      end
      rp1 = 0;
    end
  end

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input int act,
                     input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic chk_win(input string nm, input int act,
                         input int lo, input int hi);
    nvec++;
    if (act < lo || act > hi) begin
      nerr++;
      $display("FAIL %s: got %0d, want %0d..%0d",
               nm, act, lo, hi);
    end
  endtask

  task automatic preload();
    @(posedge clk);
    #1 pre = 1;
    @(posedge clk);
    #1 pre = 0;
  endtask

  task automatic go(input bit sel, input bit c,
                    input logic [7:0] f);
    @(posedge clk);
    #1;
    if (sel) start1 = 1;
    else start0 = 1;
    cmd  = c;
    fill = f;
    @(posedge clk);
    #1;
    start0 = 0;
    start1 = 0;
  endtask

  task automatic wait_done(input bit sel, input int maxc,
                           output int n);
    n = 0;
    while (!(sel ? done1 : done0) && n < maxc) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  function automatic int rd(input bit sel, input int a);
    return sel ? int'(fb1[a]) : int'(fb0[a]);
  endfunction

  function automatic int count_ne(input logic [7:0] v);
    int bad = 0;
    for (int i = 0; i < 2400; i++)
      if (fb0[i] != v) bad++;
    return bad;
  endfunction

  typedef struct {
    bit sel;
    int addr;
    int exp;
  } cell_t;

  cell_t tab[16];

  initial begin
    int n;
    int d0;

    tab[0]  = '{0, 0,       8'h50};
    tab[1]  = '{0, 1,       8'h51};
    tab[2]  = '{0, 80,      8'hA0};
    tab[3]  = '{0, 1000,    8'h38};
    tab[4]  = '{0, 2239,    8'h0F};
    tab[5]  = '{0, 2319,    8'h5F};
    tab[6]  = '{0, 2320,    8'h20};
    tab[7]  = '{0, 2399,    8'h20};
    tab[8]  = '{0, 2400,    8'h60};
    tab[9]  = '{1, 16'h3F00, 8'h50};
    tab[10] = '{1, 16'h3FFF, 8'h4F};
    tab[11] = '{1, 16'h0000, 8'h50};
    tab[12] = '{1, 16'h080F, 8'h5F};
    tab[13] = '{1, 16'h085F, 8'h20};
    tab[14] = '{1, 16'h0860, 8'h60};
    tab[15] = '{1, 16'h3EFF, 8'hFF};

    reset  = 1;
    start0 = 0;
    start1 = 0;
    cmd    = 0;
    fill   = 0;
    pre    = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_owner", int'(if0.owner), 0);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_done", int'(done0), 0);
    chk("rst_wren", int'(if0.mem_wren), 0);
    chk("rst_addr", int'(if0.mem_addr), 0);
    chk("rst_wdata", int'(if0.mem_wdata), 0);
    reset = 0;

    // Scroll, with an ignored clear request at clk 100
    preload();
    d0 = dcnt0;
    go(0, 0, 8'h20);
    fork
      wait_done(0, 12000, n);
      begin
        repeat (100) @(posedge clk);
        #1;
        start0 = 1;
        cmd    = 1;
        fill   = 8'hAA;
        @(posedge clk);
        #1 start0 = 0;
      end
    join
    chk_win("scroll_clks", n, 9438, 9442);
    repeat (5) @(posedge clk);
    #1;
    chk("scroll_done_cnt", dcnt0 - d0, 1);
    chk("scroll_busy_end", int'(busy0), 0);
    for (int i = 0; i < 16; i++)
      if (!tab[i].sel)
        chk($sformatf("scroll_cell[%0d]", tab[i].addr),
            rd(0, tab[i].addr), tab[i].exp);

    // Clear screen
    preload();
    go(0, 1, 8'hAA);
    chk("clear_busy", int'(busy0), 1);
    chk("clear_owner", int'(if0.owner), 1);
    wait_done(0, 6000, n);
    chk_win("clear_clks", n, 4798, 4802);
    chk("clear_owner_done", int'(if0.owner), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("clear_cell0", rd(0, 0), 8'hAA);
    chk("clear_cell2399", rd(0, 2399), 8'hAA);
    chk("clear_cell2400", rd(0, 2400), 8'h60);
    chk("clear_all", count_ne(8'hAA), 0);

    // Reset in the middle of a scroll, then a fresh clear
    preload();
    go(0, 0, 8'h20);
    repeat (2999) @(posedge clk);
    #1;
    chk("midop_busy", int'(busy0), 1);
    reset = 1;
    @(posedge clk);
    #1;
    chk("midrst_owner", int'(if0.owner), 0);
    chk("midrst_busy", int'(busy0), 0);
    chk("midrst_wren", int'(if0.mem_wren), 0);
    reset = 0;
    go(0, 1, 8'h33);
    wait_done(0, 6000, n);
    chk_win("reclear_clks", n, 4798, 4802);
    repeat (3) @(posedge clk);
    #1;
    chk("reclear_all", count_ne(8'h33), 0);

    // Scroll with the screen straddling the address wrap
    preload();
    go(1, 0, 8'h20);
    wait_done(1, 12000, n);
    chk_win("wrap_clks", n, 9438, 9442);
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++)
      if (tab[i].sel)
        chk($sformatf("wrap_cell[%0h]", tab[i].addr),
            rd(1, tab[i].addr), tab[i].exp);

    chk("wren_off_slot0", wbad0, 0);
    chk("wren_off_slot1", wbad1, 0);
    chk("rd_wr_addr0", pbad0, 0);
    chk("rd_wr_addr1", pbad1, 0);
    chk_win("pairs0_seen", pairs0, 2320, 5000);
    chk("pairs1_seen", pairs1, 2320);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
